// File: rtl/rf_multiport_sb_pkg.sv
// rf_pkg: shared defaults, port limits and the popcount helper used by the
// multi-port register file and its scoreboard.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_MAX_READ   = 4;
    localparam int unsigned RF_MAX_WRITE  = 2;

    // Widest busy vector popcount can take; covers ADDR_WIDTH up to 8.
    localparam int unsigned RF_POP_BITS   = 256;

    // Number of set bits in a (zero-extended) busy vector.
    function automatic int unsigned popcount(input logic [RF_POP_BITS-1:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < RF_POP_BITS; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_multiport_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits for hazard detection.
// A reserve wins over a retiring write to the same register; busy_count_o
// is the registered population count of the busy vector.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_WRITE  = 2
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic                            rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
    input  logic [NUM_WRITE-1:0]            wr_valid_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
    output logic [(1<<ADDR_WIDTH)-1:0]      busy_o,
    output logic [ADDR_WIDTH:0]             busy_count_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]       busy_q, busy_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [RF_POP_BITS-1:0] busy_ext_s;

    // Next busy state: set by reserve, else cleared by any retiring write.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            logic clr;
            logic set;
            clr = 1'b0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                clr = clr | (wr_valid_i[w] &
                             (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)));
            end
            set       = rsv_valid_i & (rsv_addr_i == ADDR_WIDTH'(r));
            busy_d[r] = set | (busy_q[r] & ~clr);
        end
    end

    // Count of busy registers after this edge.
    always_comb begin
        busy_ext_s            = '0;
        busy_ext_s[DEPTH-1:0] = busy_d;
        count_d               = (ADDR_WIDTH+1)'(popcount(busy_ext_s));
    end

    // Busy bits and count registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: NUM_READ combinational read ports, NUM_WRITE synchronous
// write ports (higher index wins on conflict), optional same-cycle bypass and
// an integrated scoreboard.
// Build option: define ZERO_REG_EN to hardwire register 0 to zero.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0]  readData,
    output logic [NUM_READ-1:0]             readBusy,
    input  logic [NUM_WRITE-1:0]            writeEnable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] writeReg,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] writeData,
    input  logic                            reserveEnable,
    input  logic [ADDR_WIDTH-1:0]           reserveReg,
    output logic [ADDR_WIDTH:0]             busyCount
);

    localparam int   DEPTH     = 1 << ADDR_WIDTH;
    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [NUM_WRITE-1:0]  wr_valid_s;
    logic                  rsv_valid_s;
    logic [DEPTH-1:0]      busy_s;

    // Qualify write and reserve strobes (register 0 may be hardwired).
    always_comb begin
        for (int w = 0; w < NUM_WRITE; w++) begin
`ifdef ZERO_REG_EN
            wr_valid_s[w] = writeEnable[w] &
                            (writeReg[w*ADDR_WIDTH +: ADDR_WIDTH] != {ADDR_WIDTH{1'b0}});
`else
            wr_valid_s[w] = writeEnable[w];
`endif
        end
`ifdef ZERO_REG_EN
        rsv_valid_s = reserveEnable & (reserveReg != {ADDR_WIDTH{1'b0}});
`else
        rsv_valid_s = reserveEnable;
`endif
    end

    // Next array contents; later write ports override earlier ones.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
            for (int w = 0; w < NUM_WRITE; w++) begin
                mem_d[r] = (wr_valid_s[w] &&
                            (writeReg[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)))
                           ? writeData[w*DATA_WIDTH +: DATA_WIDTH] : mem_d[r];
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Read ports: stored value, optionally overridden by a same-cycle write.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            logic [ADDR_WIDTH-1:0] raddr;
            logic [DATA_WIDTH-1:0] fwd;
            logic                  hit;
            raddr = readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
            fwd   = '0;
            hit   = 1'b0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                logic hit_w;
                hit_w = wr_valid_s[w] & (writeReg[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr);
                fwd   = hit_w ? writeData[w*DATA_WIDTH +: DATA_WIDTH] : fwd;
                hit   = hit | hit_w;
            end
            readData[p*DATA_WIDTH +: DATA_WIDTH] = (BYPASS_EN && hit) ? fwd : mem_q[raddr];
`ifdef ZERO_REG_EN
            if (raddr == {ADDR_WIDTH{1'b0}}) begin
                readData[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                readData[p*DATA_WIDTH +: DATA_WIDTH] = readData[p*DATA_WIDTH +: DATA_WIDTH];
            end
`endif
            readBusy[p] = busy_s[raddr] & ~(BYPASS_EN & hit);
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE)
    ) u_scoreboard (
        .clk          (clk),
        .areset       (areset),
        .rsv_valid_i  (rsv_valid_s),
        .rsv_addr_i   (reserveReg),
        .wr_valid_i   (wr_valid_s),
        .wr_addr_i    (writeReg),
        .busy_o       (busy_s),
        .busy_count_o (busyCount)
    );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench: two DUT copies (BYPASS=1 and BYPASS=0) share stimulus
// and are compared with an abstract register-file/scoreboard model.
module tb_rf_multiport_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              areset;
    logic [NR*AW-1:0]  read_reg;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wreg;
    logic [NW*DW-1:0]  wdata;
    logic              res_en;
    logic [AW-1:0]     res_reg;
    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic [NR-1:0]     rbusy_b, rbusy_n;
    logic [AW:0]       bcnt_b, bcnt_n;

    logic [DW-1:0]     m_mem [DEPTH];
    bit   [DEPTH-1:0]  m_busy;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rf_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) u_dut_byp (
        .clk(clk), .areset(areset), .readReg(read_reg), .readData(rdata_b), .readBusy(rbusy_b),
        .writeEnable(we), .writeReg(wreg), .writeData(wdata),
        .reserveEnable(res_en), .reserveReg(res_reg), .busyCount(bcnt_b));

    rf_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .areset(areset), .readReg(read_reg), .readData(rdata_n), .readBusy(rbusy_n),
        .writeEnable(we), .writeReg(wreg), .writeData(wdata),
        .reserveEnable(res_en), .reserveReg(res_reg), .busyCount(bcnt_n));

    // ---------------- reference model ----------------
    function automatic bit is_zero_reg(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
        return (a == 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data(input int p, input bit byp);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = read_reg[p*AW +: AW];
        if (is_zero_reg(a)) return 32'd0;
        v = m_mem[a];
        if (byp)
            for (int w = 0; w < NW; w++)
                if (we[w] && wreg[w*AW +: AW] == a) v = wdata[w*DW +: DW];
        return v;
    endfunction

    function automatic bit exp_busy(input int p, input bit byp);
        logic [AW-1:0] a;
        bit hit;
        a = read_reg[p*AW +: AW];
        hit = 1'b0;
        for (int w = 0; w < NW; w++)
            if (we[w] && wreg[w*AW +: AW] == a && !is_zero_reg(a)) hit = 1'b1;
        return m_busy[a] && !(byp && hit);
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_commit();
        bit [DEPTH-1:0] nb;
        nb = m_busy;
        for (int w = 0; w < NW; w++) begin
            if (we[w] && !is_zero_reg(wreg[w*AW +: AW])) begin
                m_mem[wreg[w*AW +: AW]] = wdata[w*DW +: DW];
                nb[wreg[w*AW +: AW]] = 1'b0;
            end
        end
        if (res_en && !is_zero_reg(res_reg)) nb[res_reg] = 1'b1;
        m_busy = nb;
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    task automatic idle();
        we = '0; wreg = '0; wdata = '0; res_en = 1'b0; res_reg = '0; read_reg = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b0;
        idle();
        model_reset();
        read_reg[0 +: AW] = 5'd5;
        read_reg[AW +: AW] = 5'd31;
        #1;
        checks++; if (rdata_b !== 64'd0) begin fails++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); end
        checks++; if (rdata_n !== 64'd0) begin fails++; $display("FAIL reset_rdata_n got=%h exp=0", rdata_n); end
        checks++; if ({rbusy_b, rbusy_n} !== 4'd0) begin fails++; $display("FAIL reset_busy got=%b exp=0", {rbusy_b, rbusy_n}); end
        checks++; if (bcnt_b !== 6'd0 || bcnt_n !== 6'd0) begin fails++; $display("FAIL reset_count got=%0d/%0d exp=0", bcnt_b, bcnt_n); end
        @(negedge clk);
        areset = 1'b1;
    endtask

    task automatic test_dual_write();
        @(negedge clk); idle();
        we = 2'b11; wreg = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111};
        read_reg[0 +: AW] = 5'd7;
        #1;
        checks++; if (rdata_b[0 +: DW] !== 32'h22222222) begin fails++; $display("FAIL conflict_bypass got=%h exp=22222222", rdata_b[0 +: DW]); end
        tick();
        @(negedge clk); idle(); read_reg[0 +: AW] = 5'd7; #1;
        checks++; if (rdata_n[0 +: DW] !== 32'h22222222) begin fails++; $display("FAIL conflict_stored got=%h exp=22222222", rdata_n[0 +: DW]); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_v;
        @(negedge clk); idle();
        old_v = m_mem[3];
        we = 2'b01; wreg[0 +: AW] = 5'd3; wdata[0 +: DW] = 32'hCAFEF00D;
        read_reg[0 +: AW] = 5'd3;
        #1;
        checks++; if (rdata_b[0 +: DW] !== 32'hCAFEF00D) begin fails++; $display("FAIL bypass_same got=%h exp=cafef00d", rdata_b[0 +: DW]); end
        checks++; if (rdata_n[0 +: DW] !== old_v) begin fails++; $display("FAIL nobypass_old got=%h exp=%h", rdata_n[0 +: DW], old_v); end
        tick();
        @(negedge clk); idle(); read_reg[0 +: AW] = 5'd3; #1;
        checks++; if (rdata_n[0 +: DW] !== 32'hCAFEF00D) begin fails++; $display("FAIL nobypass_next got=%h exp=cafef00d", rdata_n[0 +: DW]); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle();
        res_en = 1'b1; res_reg = 5'd9;
        tick();
        checks++; if (bcnt_b !== 6'd1 || bcnt_n !== 6'd1) begin fails++; $display("FAIL sb_count_set got=%0d/%0d exp=1", bcnt_b, bcnt_n); end
        @(negedge clk); idle(); read_reg[AW +: AW] = 5'd9; #1;
        checks++; if (rbusy_b[1] !== 1'b1 || rbusy_n[1] !== 1'b1) begin fails++; $display("FAIL sb_busy got=%b/%b exp=1", rbusy_b[1], rbusy_n[1]); end
        @(negedge clk); idle(); read_reg[AW +: AW] = 5'd9;
        we = 2'b10; wreg[AW +: AW] = 5'd9; wdata[DW +: DW] = 32'h5;
        #1;
        checks++; if (rbusy_b[1] !== 1'b0) begin fails++; $display("FAIL sb_busy_masked got=%b exp=0", rbusy_b[1]); end
        checks++; if (rbusy_n[1] !== 1'b1) begin fails++; $display("FAIL sb_busy_unmasked got=%b exp=1", rbusy_n[1]); end
        tick();
        checks++; if (bcnt_b !== 6'd0 || bcnt_n !== 6'd0) begin fails++; $display("FAIL sb_count_clr got=%0d/%0d exp=0", bcnt_b, bcnt_n); end
    endtask

    task automatic test_reserve_write();
        @(negedge clk); idle();
        res_en = 1'b1; res_reg = 5'd4;
        we = 2'b01; wreg[0 +: AW] = 5'd4; wdata[0 +: DW] = 32'hA5A5A5A5;
        tick();
        @(negedge clk); idle(); read_reg[0 +: AW] = 5'd4; #1;
        checks++; if (rdata_n[0 +: DW] !== 32'hA5A5A5A5) begin fails++; $display("FAIL rsvwr_data got=%h exp=a5a5a5a5", rdata_n[0 +: DW]); end
        checks++; if (rbusy_n[0] !== 1'b1 || rbusy_b[0] !== 1'b1) begin fails++; $display("FAIL rsvwr_busy got=%b/%b exp=1", rbusy_b[0], rbusy_n[0]); end
        checks++; if (bcnt_b !== 6'd1) begin fails++; $display("FAIL rsvwr_count got=%0d exp=1", bcnt_b); end
        // Reserve of an already-busy register leaves the count alone.
        @(negedge clk); idle(); res_en = 1'b1; res_reg = 5'd4;
        tick();
        checks++; if (bcnt_b !== 6'd1 || bcnt_n !== 6'd1) begin fails++; $display("FAIL rsv_again_count got=%0d/%0d exp=1", bcnt_b, bcnt_n); end
        @(negedge clk); idle(); we = 2'b01; wreg[0 +: AW] = 5'd4; wdata[0 +: DW] = 32'h0;
        tick();
    endtask

    task automatic test_zero_reg();
        int cnt0;
        cnt0 = exp_count();
        @(negedge clk); idle();
        we = 2'b10; wreg[AW +: AW] = 5'd0; wdata[DW +: DW] = 32'hFFFFFFFF;
        res_en = 1'b1; res_reg = 5'd0;
        read_reg[0 +: AW] = 5'd0;
        #1;
`ifdef ZERO_REG_EN
        checks++; if (rdata_b[0 +: DW] !== 32'd0) begin fails++; $display("FAIL zero_bypass got=%h exp=0", rdata_b[0 +: DW]); end
`else
        checks++; if (rdata_b[0 +: DW] !== 32'hFFFFFFFF) begin fails++; $display("FAIL r0_bypass got=%h exp=ffffffff", rdata_b[0 +: DW]); end
`endif
        tick();
        @(negedge clk); idle(); read_reg[0 +: AW] = 5'd0; #1;
`ifdef ZERO_REG_EN
        checks++; if (rdata_n[0 +: DW] !== 32'd0) begin fails++; $display("FAIL zero_read got=%h exp=0", rdata_n[0 +: DW]); end
        checks++; if (rbusy_n[0] !== 1'b0) begin fails++; $display("FAIL zero_busy got=%b exp=0", rbusy_n[0]); end
        checks++; if (int'(bcnt_n) != cnt0) begin fails++; $display("FAIL zero_count got=%0d exp=%0d", bcnt_n, cnt0); end
`else
        checks++; if (rdata_n[0 +: DW] !== 32'hFFFFFFFF) begin fails++; $display("FAIL r0_read got=%h exp=ffffffff", rdata_n[0 +: DW]); end
        checks++; if (rbusy_n[0] !== 1'b1) begin fails++; $display("FAIL r0_busy got=%b exp=1", rbusy_n[0]); end
        checks++; if (int'(bcnt_n) != cnt0 + 1) begin fails++; $display("FAIL r0_count got=%0d exp=%0d", bcnt_n, cnt0 + 1); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) read_reg[p*AW +: AW] = AW'($urandom_range(0, 7));
            for (int w = 0; w < NW; w++) begin
                we[w] = ($urandom_range(0, 2) == 0);
                wreg[w*AW +: AW] = AW'($urandom_range(0, 7));
                wdata[w*DW +: DW] = $urandom;
            end
            res_en = ($urandom_range(0, 2) == 0);
            res_reg = AW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < NR; p++) begin
                checks++; if (rdata_b[p*DW +: DW] !== exp_data(p, 1'b1)) begin fails++; $display("FAIL rnd_rdata_b[%0d] i=%0d got=%h exp=%h", p, i, rdata_b[p*DW +: DW], exp_data(p, 1'b1)); end
                checks++; if (rdata_n[p*DW +: DW] !== exp_data(p, 1'b0)) begin fails++; $display("FAIL rnd_rdata_n[%0d] i=%0d got=%h exp=%h", p, i, rdata_n[p*DW +: DW], exp_data(p, 1'b0)); end
                checks++; if (rbusy_b[p] !== exp_busy(p, 1'b1)) begin fails++; $display("FAIL rnd_busy_b[%0d] i=%0d got=%b exp=%b", p, i, rbusy_b[p], exp_busy(p, 1'b1)); end
                checks++; if (rbusy_n[p] !== exp_busy(p, 1'b0)) begin fails++; $display("FAIL rnd_busy_n[%0d] i=%0d got=%b exp=%b", p, i, rbusy_n[p], exp_busy(p, 1'b0)); end
            end
            tick();
            checks++; if (int'(bcnt_b) != exp_count() || int'(bcnt_n) != exp_count()) begin fails++; $display("FAIL rnd_count i=%0d got=%0d/%0d exp=%0d", i, bcnt_b, bcnt_n, exp_count()); end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); idle();
        we = 2'b01; wreg[0 +: AW] = 5'd5; wdata[0 +: DW] = 32'hDEADBEEF;
        res_en = 1'b1; res_reg = 5'd12;
        tick();
        @(negedge clk); idle(); read_reg[0 +: AW] = 5'd5; #1;
        checks++; if (rdata_n[0 +: DW] !== 32'hDEADBEEF) begin fails++; $display("FAIL midrst_pre got=%h exp=deadbeef", rdata_n[0 +: DW]); end
        #2 areset = 1'b0;
        model_reset();
        #1;
        checks++; if (rdata_b[0 +: DW] !== 32'd0 || rdata_n[0 +: DW] !== 32'd0) begin fails++; $display("FAIL midrst_data got=%h/%h exp=0", rdata_b[0 +: DW], rdata_n[0 +: DW]); end
        checks++; if (bcnt_b !== 6'd0 || bcnt_n !== 6'd0) begin fails++; $display("FAIL midrst_count got=%0d/%0d exp=0", bcnt_b, bcnt_n); end
        @(negedge clk); areset = 1'b1;
        // First edge after release behaves normally.
        @(negedge clk); idle(); res_en = 1'b1; res_reg = 5'd2;
        tick();
        checks++; if (bcnt_b !== 6'd1) begin fails++; $display("FAIL midrst_after got=%0d exp=1", bcnt_b); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_reserve_write();
        test_zero_reg();
        test_random();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
